result_frame_writer: RTL and testbench
======================================

RESULT_FRAME_WRITER -- requirements
Module: result_frame_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 256, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 256, image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 16, frame-buffer address width, where IMG_W*IMG_H <= 2^ADDR_W.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin capturing one frame.
REQ-007 SHALL have port in_valid, input, 1, strobe from the kernel stage meaning in_data holds one filtered pixel.
REQ-008 SHALL have port in_data, input, 17, filtered pixel result from the kernel-mode mux, two's complement.
REQ-009 SHALL have port wr_en, output, 1, frame-buffer write strobe.
REQ-010 SHALL have port wr_addr, output, ADDR_W, frame-buffer write address, raster order.
REQ-011 SHALL have port wr_data, output, 8, clamped pixel.
REQ-012 SHALL have port busy, output, 1, high while a frame capture is in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when the frame is complete.
REQ-014 SHALL have port sat_count, output, 16, number of clamped pixels in the current or last frame.
REQ-015 SHALL have port stray_err, output, 1, sticky flag for in_valid received while not capturing.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE, with IDLE entered on reset.
REQ-017 SHALL move IDLE->RUN on start; in the same edge it clears the pixel counter, sat_count and stray_err.
REQ-018 SHALL ignore start while in RUN or DONE: no restart and no counter clear.
REQ-019 SHALL, in RUN, accept the pixel on every cycle with in_valid=1; no backpressure exists and every strobe is consumed.
REQ-020 SHALL clamp the value as follows: in_data[16]=1 (negative) -> 0; in_data > 255 -> 255; otherwise in_data[7:0].
REQ-021 SHALL increment sat_count on each accepted pixel that clamps (either direction), saturating at 0xFFFF without wrap.
REQ-022 SHALL have a latency of exactly 1 cycle: pixel accepted at edge N drives wr_en=1 with wr_data and wr_addr during cycle N+1; wr_en is high for one cycle per accepted pixel.
REQ-023 SHALL use wr_addr equal to the count of pixels previously accepted in this frame: first pixel -> 0, last -> IMG_W*IMG_H-1.
REQ-024 SHALL move RUN->DONE on the edge that accepts pixel number IMG_W*IMG_H-1; the final write is still issued in the next cycle.
REQ-025 SHALL hold DONE for exactly 1 cycle, with done=1 in that cycle (coincident with the final wr_en), then move to IDLE.
REQ-026 SHALL assert busy in RUN and DONE and deassert it in IDLE.
REQ-027 SHALL set stray_err on in_valid=1 in IDLE or DONE and write nothing for that strobe; stray_err clears only on accepted start or on reset.
REQ-028 SHALL, on simultaneous start and in_valid in IDLE, start capture, not accept that pixel and not set stray_err.
REQ-029 SHALL freeze the internal pixel counter and sat_count after DONE until the next accepted start; wr_addr wraps only by the restart, never by incrementing past IMG_W*IMG_H-1.
REQ-030 SHALL hold wr_addr and wr_data at their last written values while wr_en=0.

Reset
REQ-031 SHALL, on rst=1, immediately and independently of clk, force: state IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, sat_count=0, stray_err=0.
REQ-032 SHALL, on rst asserted mid-frame, abandon the frame without producing done or any further write; a new start is required after rst deasserts.

Verification
REQ-033 SHALL be verified with a full frame: start, then 65536 strobes of value 100 -> 65536 writes at addr 0..65535 with data 0x64, done once coincident with the addr-65535 write, sat_count=0, busy=0 afterwards.
REQ-034 SHALL be verified for clamping: in RUN send -5, 0, 255, 256, 0x0FFFF -> wr_data 0, 0, 255, 255, 255 at consecutive addresses, each one cycle after input, sat_count=3.
REQ-035 SHALL be verified for strays: in_valid=1 while idle -> no wr_en and stray_err=1; then start -> stray_err=0.
REQ-036 SHALL be verified for collisions: start pulsed at frame address 1000 -> ignored, addresses continue 1001, 1002 and sat_count is not cleared; start with in_valid in the same IDLE cycle -> first write at addr 0 comes from the next strobe.
REQ-037 SHALL be verified for reset mid-frame: rst pulsed at address 30000 -> outputs go to the REQ-031 values before the next clk edge, no done; after restart the first write is at addr 0.
REQ-038 SHALL be verified for gapped input: strobes with random 0-3 cycle gaps -> strictly sequential addresses, no duplicated or missing writes.

Source files
------------

// File: rtl/result_frame_writer.sv
// result_frame_writer
// Captures one frame of filtered 17-bit two's-complement kernel results,
// clamps each to an 8-bit pixel and writes it to a frame buffer in raster
// order one cycle after acceptance. Tracks clamped-pixel count and flags
// pixel strobes that arrive while no capture is active.
module result_frame_writer #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [16:0]       in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sat_count,
  output logic              stray_err
);

  localparam int unsigned       TOTAL     = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;   // pixels already accepted in this frame
  logic [7:0]        clamped;
  logic              clipped;

  // Clamp the signed kernel result into the 0..255 pixel range.
  always_comb begin
    clamped = in_data[7:0];
    clipped = 1'b0;
    if (in_data[16]) begin
      clamped = 8'd0;
      clipped = 1'b1;
    end else if (|in_data[15:8]) begin
      clamped = 8'hFF;
      clipped = 1'b1;
    end
  end

  // Frame capture FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_count <= 16'd0;
      stray_err <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A strobe coinciding with start is dropped and is not a stray.
            state     <= RUN;
            busy      <= 1'b1;
            pix_cnt   <= '0;
            sat_count <= 16'd0;
            stray_err <= 1'b0;
          end else if (in_valid) begin
            stray_err <= 1'b1;
          end
        end
        RUN: begin
          // start is ignored here: no restart, no counter clear.
          if (in_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= pix_cnt;
            wr_data <= clamped;
            if (clipped && (sat_count != 16'hFFFF)) begin
              sat_count <= sat_count + 16'd1;
            end
            if (pix_cnt == LAST_ADDR) begin
              // Counter stays frozen at the last address until restart.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (in_valid) begin
            stray_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_frame_writer.sv
// tb_result_frame_writer
// Drives result_frame_writer cycle by cycle and compares every output on
// every cycle against a behavioural model of the frame-capture rules.
module tb_result_frame_writer;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 16;
  localparam int TOTAL  = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [16:0]       in_data = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic [15:0]       sat_count;
  logic              stray_err;

  result_frame_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .sat_count(sat_count), .stray_err(stray_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: "capturing" = a frame is open and accepting pixels,
  // "finishing" = the single cycle after the last pixel was accepted.
  bit m_capturing, m_finishing, m_stray;
  int m_accepted, m_sat;
  bit e_wr_en, e_done;
  int e_addr, e_data;

  typedef struct {
    logic [16:0] din;
    int          exp_data;
    int          exp_sat_inc;
  } clamp_vec_t;
  clamp_vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_ref(input logic [16:0] d);
    int x;
    x = int'($signed(d));
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  task automatic model_reset();
    m_capturing = 0; m_finishing = 0; m_stray = 0;
    m_accepted = 0; m_sat = 0;
    e_wr_en = 0; e_done = 0; e_addr = 0; e_data = 0;
  endtask

  // Apply the rules for one rising edge with the given inputs.
  task automatic model_edge(input bit s, input bit v, input logic [16:0] d);
    int c;
    e_wr_en = 0;
    e_done  = 0;
    if (m_finishing) begin
      m_finishing = 0;
      if (v) m_stray = 1;
    end else if (m_capturing) begin
      if (v) begin
        c = clamp_ref(d);
        e_wr_en = 1;
        e_addr  = m_accepted;
        e_data  = c;
        if (int'($signed(d)) != c && m_sat < 65535) m_sat++;
        m_accepted++;
        if (m_accepted == TOTAL) begin
          m_capturing = 0;
          m_finishing = 1;
          e_done      = 1;
        end
      end
    end else begin
      if (s) begin
        m_capturing = 1; m_accepted = 0; m_sat = 0; m_stray = 0;
      end else if (v) begin
        m_stray = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("wr_en", int'(wr_en), int'(e_wr_en));
    chk("wr_addr", int'(wr_addr), e_addr);
    chk("wr_data", int'(wr_data), e_data);
    chk("busy", int'(busy), int'(m_capturing || m_finishing));
    chk("done", int'(done), int'(e_done));
    chk("sat_count", int'(sat_count), m_sat);
    chk("stray_err", int'(stray_err), int'(m_stray));
  endtask

  // One clock cycle: drive, edge, model update, check on the falling edge.
  task automatic cyc(input bit s, input bit v, input logic [16:0] d);
    start = s; in_valid = v; in_data = d;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(s, v, d);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [16:0] rand_pix();
    logic [16:0] r;
    case ($urandom_range(0, 3))
      0: r = 17'($urandom);
      1: r = 17'($urandom_range(0, 255));
      2: r = 17'(-$urandom_range(1, 300));
      default: r = 17'($urandom_range(200, 400));
    endcase
    return r;
  endfunction

  initial begin
    tbl[0] = '{17'h1FFFB, 0,   1};  // -5
    tbl[1] = '{17'h00000, 0,   0};
    tbl[2] = '{17'h000FF, 255, 0};
    tbl[3] = '{17'h00100, 255, 1};  // 256
    tbl[4] = '{17'h0FFFF, 255, 1};
    tbl[5] = '{17'h10000, 0,   1};  // most negative
    tbl[6] = '{17'h00080, 128, 0};
    tbl[7] = '{17'h00001, 1,   0};

    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Stray strobe while idle, then start clears it
    cyc(0, 1, 17'd9);
    chk("stray_set", int'(stray_err), 1);
    cyc(0, 0, 17'd0);
    cyc(1, 0, 17'd0);
    chk("stray_clr", int'(stray_err), 0);

    // Clamping table, each written one cycle after its input
    for (int i = 0; i < 8; i++) begin
      int sat_before;
      sat_before = m_sat;
      cyc(0, 1, tbl[i].din);
      chk("tbl_data", int'(wr_data), tbl[i].exp_data);
      chk("tbl_addr", int'(wr_addr), i);
      chk("tbl_sat", int'(sat_count), sat_before + tbl[i].exp_sat_inc);
    end

    // Random pixels up to address 1000, then start collides with a strobe
    while (m_accepted < 1000) cyc(0, 1, rand_pix());
    begin
      int sat_before;
      sat_before = m_sat;
      cyc(1, 1, 17'd300);
      chk("coll_addr0", int'(wr_addr), 1000);
      cyc(0, 1, 17'd5);
      chk("coll_addr1", int'(wr_addr), 1001);
      cyc(0, 1, 17'd6);
      chk("coll_addr2", int'(wr_addr), 1002);
      chk("coll_sat", int'(sat_count), sat_before + 1);
    end

    // Gapped random strobes
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cyc(0, 0, rand_pix());
      cyc(0, 1, rand_pix());
    end

    // Continue to address 30000 then reset asynchronously mid-frame
    while (m_accepted < 30000) cyc(0, 1, rand_pix());
    in_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cyc(0, 1, 17'd7);
    cyc(1, 1, 17'd7);
    rst = 1'b0;

    // After reset the writer sits idle; a strobe is a stray
    cyc(0, 1, 17'd50);
    chk("post_rst_stray", int'(stray_err), 1);

    // Start with a simultaneous strobe: that strobe is dropped
    cyc(1, 1, 17'd77);
    chk("start_coinc_we", int'(wr_en), 0);
    chk("start_coinc_stray", int'(stray_err), 0);

    // Full frame of value 100
    for (int i = 0; i < TOTAL; i++) begin
      cyc(0, 1, 17'd100);
      if (i == 0) chk("first_addr", int'(wr_addr), 0);
    end
    chk("last_addr", int'(wr_addr), TOTAL - 1);
    chk("last_data", int'(wr_data), 8'h64);
    chk("last_done", int'(done), 1);

    // start and a strobe during the DONE cycle: start ignored, stray flagged
    cyc(1, 1, 17'd100);
    chk("after_busy", int'(busy), 0);
    chk("after_stray", int'(stray_err), 1);
    cyc(0, 0, 17'd0);
    cyc(0, 1, 17'd100);
    chk("idle_no_write", int'(wr_en), 0);
    chk("frozen_addr", int'(wr_addr), TOTAL - 1);
    chk("frozen_sat", int'(sat_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
